// File: rtl/pdm_mic_capture_pkg.sv
// Shared audio definitions for the PDM capture path and the playback chain.
package pdm_mic_capture_pkg;

    // 8-bit unsigned audio sample, same format the playback path consumes
    typedef logic [7:0] audio_sample_t;

    localparam int unsigned MIC_CLK_DIV_DEFAULT       = 12;
    localparam int unsigned PDM_DECIM_DEFAULT         = 256;
    localparam int unsigned SAMPLE_FIFO_DEPTH_DEFAULT = 16;

    // Clamp a scaled ones-count to the 8-bit sample range
    function automatic audio_sample_t sat_sample(input logic [16:0] v);
        return (v > 17'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/pdm_mic_capture_if.sv
// Sample stream handshake between the capture block and its consumer.
interface pdm_mic_capture_if;
    import pdm_mic_capture_pkg::*;

    audio_sample_t sample_out;
    logic          sample_valid;
    logic          sample_ready;

    // Producer side (capture block)
    modport master (
        output sample_out,
        output sample_valid,
        input  sample_ready
    );

    // Consumer side (recorder / loopback)
    modport slave (
        input  sample_out,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/pdm_mic_capture_sync_fifo.sv
// Generic single-clock FIFO with combinational head read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO still succeeds when the head leaves in the same edge
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone capture: mic clock divider, input synchronizer, ones-count
// decimator and a sample FIFO drained through a valid/ready handshake.
module pdm_mic_capture
    import pdm_mic_capture_pkg::*;
#(
    parameter int unsigned MIC_CLK_DIV = MIC_CLK_DIV_DEFAULT,
    parameter int unsigned DECIM       = PDM_DECIM_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = SAMPLE_FIFO_DEPTH_DEFAULT
) (
    input  logic              clk_25MHZ,
    input  logic              rst,
    input  logic              en,
    input  logic              mic_data,
    output logic              mic_clk,
    output logic              mic_lr_sel,
    output logic              overflow,
    pdm_mic_capture_if.master smp
);

    localparam int unsigned DW    = $clog2(MIC_CLK_DIV);
    localparam int unsigned BW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned SHIFT = 8 - $clog2(DECIM);

    localparam logic [DW-1:0] DIV_LAST = DW'(MIC_CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(MIC_CLK_DIV / 2);
    localparam logic [DW-1:0] CAP_AT   = DW'(MIC_CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DECIM - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          mic_clk_q, mic_clk_d;
    logic          sync1_q, sync2_q;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [8:0]    ones_cnt_q, ones_cnt_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic [8:0]    window_sum;
    logic [16:0]   window_scaled;
    audio_sample_t sample_new;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    audio_sample_t fifo_dout;

    // Closing sample includes the bit captured in the same cycle
    assign window_sum    = ones_cnt_q + 9'(sync2_q);
    assign window_scaled = 17'(window_sum) << SHIFT;
    assign sample_new    = sat_sample(window_scaled);

    // Divider, capture strobe and window accumulation; en low parks everything at 0
    always_comb begin
        div_cnt_d  = div_cnt_q;
        mic_clk_d  = mic_clk_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        push       = 1'b0;
        if (!en) begin
            div_cnt_d  = '0;
            mic_clk_d  = 1'b0;
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
        end else begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
            mic_clk_d = (div_cnt_q < DIV_HALF);
            if (div_cnt_q == CAP_AT) begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                    push       = 1'b1;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    ones_cnt_d = window_sum;
                end
            end
        end
    end

    assign fifo_pop = !fifo_empty && smp.sample_ready;

    // Drop is flagged only when the FIFO cannot make room in the same edge
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    // Capture-path state registers
    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            div_cnt_q  <= '0;
            mic_clk_q  <= 1'b0;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            mic_clk_q  <= mic_clk_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Two-flop synchronizer for the asynchronous PDM data
    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mic_data;
            sync2_q <= sync1_q;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_25MHZ),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .din   (sample_new),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mic_clk          = mic_clk_q;
    assign mic_lr_sel       = 1'b0;
    assign overflow         = overflow_q;
    assign smp.sample_out   = fifo_dout;
    assign smp.sample_valid = !fifo_empty;

endmodule
